// File: rtl/modulus_pkg.sv
// Shared FSM state type and sizing helpers for the radix-2^k modulus unit.
package modulus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Number of digit-retirement iterations for a 2*width dividend.
    function automatic int unsigned calc_steps(input int unsigned width,
                                               input int unsigned radix_bits);
        return (2 * width) / radix_bits;
    endfunction

    // Bits needed for a counter running 0..steps-1.
    function automatic int unsigned cnt_width(input int unsigned steps);
        return (steps > 2) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/mod_digit_select.sv
// Picks the largest digit d with d*m <= partial and returns partial - d*m.
module mod_digit_select #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned RADIX_BITS = 2
) (
    input  logic [WIDTH+RADIX_BITS-1:0] partial,
    input  logic [WIDTH-1:0]            modulus,
    output logic [RADIX_BITS-1:0]       digit,
    output logic [WIDTH-1:0]            remainder
);

    localparam int unsigned WW         = WIDTH + RADIX_BITS;
    localparam int unsigned NUM_DIGITS = 1 << RADIX_BITS;

    logic [WW-1:0] multiple;
    logic [WW-1:0] chosen;

    // Compares are independent; the last satisfied multiple wins since they are monotonic.
    always_comb begin
        digit    = '0;
        chosen   = '0;
        multiple = '0;
        for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
            multiple = WW'(k) * WW'(modulus);
            if (partial >= multiple) begin
                digit  = RADIX_BITS'(k);
                chosen = multiple;
            end
        end
        remainder = WIDTH'(partial - chosen);
    end

endmodule

// File: rtl/modulus_radix.sv
// Iterative 2*WIDTH / WIDTH modulus, RADIX_BITS dividend bits retired per cycle.
// Define MODULUS_QUOTIENT_EN to also expose the quotient on quotient_out.
module modulus_radix
    import modulus_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned RADIX_BITS = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [2*WIDTH-1:0]   value_in,
    input  logic [WIDTH-1:0]     modulus_in,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [WIDTH-1:0]     value_out,
    output logic                 err_out
`ifdef MODULUS_QUOTIENT_EN
    ,
    output logic [2*WIDTH-1:0]   quotient_out
`endif
);

    localparam int unsigned STEPS = calc_steps(WIDTH, RADIX_BITS);
    localparam int unsigned CW    = cnt_width(STEPS);

    state_t                  state;
    state_t                  state_next;
    logic                    accept;
    logic                    step;
    logic [2*WIDTH-1:0]      dividend;
    logic [WIDTH-1:0]        modulus;
    logic [WIDTH-1:0]        rem;
    logic [CW-1:0]           cnt;
    logic                    err;
    logic [RADIX_BITS-1:0]   digit;
    logic [WIDTH-1:0]        rem_next;
    logic [WIDTH+RADIX_BITS-1:0] partial;

    assign partial = {rem, dividend[2*WIDTH-1 -: RADIX_BITS]};

    mod_digit_select #(
        .WIDTH      (WIDTH),
        .RADIX_BITS (RADIX_BITS)
    ) u_digit_select (
        .partial   (partial),
        .modulus   (modulus),
        .digit     (digit),
        .remainder (rem_next)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= ST_IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (valid_in) state_next = (modulus_in == '0) ? ST_DONE : ST_REDUCE;
            ST_REDUCE: if (cnt == CW'(STEPS - 1)) state_next = ST_DONE;
            ST_DONE:   if (ready_in) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_out = 1'b0;
        valid_out = 1'b0;
        step      = 1'b0;
        case (state)
            ST_IDLE:   ready_out = 1'b1;
            ST_REDUCE: step      = 1'b1;
            ST_DONE:   valid_out = 1'b1;
            default:   ready_out = 1'b0;
        endcase
        accept = ready_out && valid_in;
    end

    // Remainder datapath; the remainder register doubles as the result output.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            dividend <= '0;
            modulus  <= '0;
            rem      <= '0;
            cnt      <= '0;
            err      <= 1'b0;
        end else if (accept) begin
            dividend <= value_in;
            modulus  <= modulus_in;
            rem      <= '0;
            cnt      <= '0;
            err      <= (modulus_in == '0);
        end else if (step) begin
            dividend <= dividend << RADIX_BITS;
            rem      <= rem_next;
            cnt      <= cnt + CW'(1);
        end
    end

    assign value_out = rem;
    assign err_out   = err;

`ifdef MODULUS_QUOTIENT_EN
    logic [2*WIDTH-1:0] quot;

    // A zero modulus reports an all-ones quotient.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            quot <= '0;
        end else if (accept) begin
            quot <= (modulus_in == '0) ? '1 : '0;
        end else if (step) begin
            quot <= {quot[2*WIDTH-RADIX_BITS-1:0], digit};
        end
    end

    assign quotient_out = quot;
`else
    logic unused_digit;
    assign unused_digit = ^digit;
`endif

endmodule
